// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a small register file: one address byte (R/W + index)
// followed by one data byte per frame. All SPI pins are oversampled in clk.
module spi_slave_regs #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 16,
    parameter int ADDR_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    output logic                  wr_valid,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_err,
    input  logic [ADDR_BITS-1:0]  dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ADDR, DATA} state_t;

    state_t                 state;
    logic [2:0]             ss_pipe;
    logic [2:0]             sclk_pipe;
    logic [1:0]             mosi_pipe;
    logic [1:0]             primed;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [ADDR_BITS-1:0]   idx;
    logic                   is_read;
    logic [DATA_WIDTH-1:0]  regs [REG_COUNT];

    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, ss_s, mosi_s;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic [ADDR_BITS-1:0]   idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_pipe   <= '1;
            sclk_pipe <= '0;
            mosi_pipe <= '0;
        end else begin
            ss_pipe   <= {ss_pipe[1:0], ss};
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            mosi_pipe <= {mosi_pipe[0], mosi};
        end
    end

    always_comb begin
        ss_s      = ss_pipe[1];
        mosi_s    = mosi_pipe[1];
        sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
        sclk_fall = ~sclk_pipe[1] & sclk_pipe[2];
        ss_rise   = ss_pipe[1] & ~ss_pipe[2];
        ss_fall   = ~ss_pipe[1] & ss_pipe[2];
        rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
        idx_next  = rx_next[ADDR_BITS-1:0];
        dbg_data  = regs[dbg_addr];
    end

    // primed masks the synchronizer's reset value of ss: WAIT_IDLE only trusts
    // ss_s once it reflects the real pin, so a reset mid-frame waits for ss high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_IDLE;
            primed    <= '0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            idx       <= '0;
            is_read   <= 1'b0;
            miso      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            primed    <= {primed[0], 1'b1};
            case (state)
                WAIT_IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    if (primed[1] && ss_s) state <= IDLE;
                end
                IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    if (ss_fall) state <= ADDR;
                end
                ADDR: begin
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            is_read <= rx_next[DATA_WIDTH-1];
                            idx     <= idx_next;
                            state   <= DATA;
                            if (rx_next[DATA_WIDTH-1]) begin
                                tx_shift <= regs[idx_next];
                                miso     <= regs[idx_next][DATA_WIDTH-1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    // Final rise wins over a coincident ss rise.
                    if (sclk_rise && bit_cnt == LAST_BIT) begin
                        rx_shift <= rx_next;
                        miso     <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= WAIT_IDLE;
                        if (!is_read) begin
                            regs[idx] <= rx_next;
                            wr_valid  <= 1'b1;
                            wr_addr   <= idx;
                            wr_data   <= rx_next;
                        end
                    end else if (ss_rise) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else if (sclk_fall && is_read && bit_cnt != '0) begin
                        // The fall right after the 8th address rise keeps the MSB.
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        miso     <= tx_shift[DATA_WIDTH-2];
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule
